lfsr_rng_ctrl: RTL and testbench
================================

Name: lfsr_rng_ctrl

Overview:
- Controller that owns an 8-bit Galois LFSR (x^8+x^4+x^3+x^2+1), handles seeding and warm-up, and serves random bytes.
- Two requesters share the generator through round-robin arbitration and a req/ack handshake.
- Each grant returns the current LFSR byte and advances the LFSR exactly one step, so the output sequence is deterministic per seed.
- Sits between the LFSR datapath and consumers such as test-pattern and scrambler blocks.

Parameters:
- RESET_SEED, 8'h01, LFSR value loaded on reset. A value of 0 is replaced by 8'h01.
- WARMUP, 8, number of free-running steps after reset or seed load before serving. Range 0..255.

Ports:
- clk  in  1  rising-edge clock
- res_n  in  1  synchronous reset, active-low
- seed_in  in  8  seed value, sampled when seed_load=1
- seed_load  in  1  single-cycle pulse; reseeds the LFSR and restarts warm-up
- req  in  2  level request per requester; held until ack is seen
- ack  out  2  one-cycle grant strobe, one-hot or zero; registered
- rnd_data  out  8  byte for the acked requester; valid while ack≠0, holds otherwise; registered
- ready  out  1  1 when in READY state; registered

Behaviour:
- Clock and reset: one clock (clk); reset is synchronous and active-low (res_n).
- Step function, next state from s:
  - n0=s7, n1=s0, n2=s1^s7, n3=s2^s7, n4=s3^s7, n5=s4, n6=s5, n7=s6
  - 0x00 is a lock-up state and is never allowed in the LFSR.
- Reset (res_n=0 at an edge):
  - lfsr=RESET_SEED (0 replaced by 0x01), warm_cnt=0, rr=0
  - ack=0, rnd_data=0x00, ready=0
  - state=WARM, or READY if WARMUP=0
- States:
  - WARM: LFSR steps every cycle; warm_cnt increments. When warm_cnt==WARMUP-1, go to READY. No grants.
  - READY: LFSR holds. If any req bit is set, pick the winner:
    - only one requester asserting: that requester wins
    - both asserting: requester rr wins
  - On a win: next cycle ack[w]=1, rnd_data=current lfsr; lfsr steps once; rr=~w; state→ACK.
  - ACK: one cycle, no new grant (lets requesters drop req after seeing ack). Then →READY.
- Throughput: at most one byte per 2 cycles. Latency is req high in READY → ack on the next cycle.
- Both requesters holding req: grants alternate 0,1,0,1… starting from rr.
- seed_load, highest priority, any state:
  - lfsr=(seed_in==0 ? 0x01 : seed_in), warm_cnt=0, state=WARM (READY if WARMUP=0)
  - no grant is issued from that cycle
  - an ack already registered for the current cycle stays visible; rr is preserved
- seed_load and res_n=0 in the same cycle: reset wins.
- req change while in WARM or ACK: ignored; only the level seen in READY matters.
- warm_cnt is 8 bits and never wraps, because WARMUP≤255.

Optional Feature:
- Macro: LFSR_GNT_CNT_EN.
- With the macro defined:
  - extra output ports gnt_cnt0 and gnt_cnt1, 8 bits each
  - each increments on its requester's ack and wraps 255→0
  - both reset to 0 on res_n=0; seed_load does not clear them
- Without the macro: the ports and counters do not exist; all other behaviour is identical.

Decomposition:
- Package lfsr_pkg holds:
  - LFSR_W=8
  - tap mask TAPS=8'h1C (bits receiving s7 XOR)
  - ZERO_SUB=8'h01
  - state enum {WARM, READY, ACK}
  - function lfsr_next(s)
- One natural sub-module, lfsr_core: 8-bit register with load (value), step (enable) and hold. The controller drives load/step. Load wins over step.

Test Plan:
- Reset, RESET_SEED=0x01, WARMUP=8, no req → ready rises after 8 cycles in WARM; lfsr=0x1D; ack=0, rnd_data=0x00 throughout.
- Then req=2'b01 held until ack → ack=01 with rnd_data=0x1D; next grant gives 0x3A, then 0x74; ack never on two consecutive cycles.
- req=2'b11 held continuously → acks alternate 01,10,01,10 starting with requester 0; data follows the single LFSR sequence with no skipped step.
- seed_load with seed_in=0x00 while in READY → lfsr reseeded to 0x01, ready=0 for 8 cycles, no ack meanwhile; first byte after warm-up is 0x1D.
- seed_load in the ACK cycle with req=11 → the current ack still visible, the next state is WARM, no further ack until ready returns; rr order continues correctly.
- With LFSR_GNT_CNT_EN: 300 grants to requester 0 → gnt_cnt0=44 (wrapped), gnt_cnt1=0; res_n=0 clears both.

Source files
------------

// File: rtl/lfsr_pkg.sv
// Shared LFSR definitions: width, Galois tap mask, zero-seed substitute,
// controller state enum and the single-step / seed-sanitize helpers.
package lfsr_pkg;

  localparam int LFSR_W = 8;
  localparam logic [LFSR_W-1:0] TAPS = 8'h1C;
  localparam logic [LFSR_W-1:0] ZERO_SUB = 8'h01;

  typedef enum logic [1:0] {
    WARM  = 2'd0,
    READY = 2'd1,
    ACK   = 2'd2
  } state_t;

  // Galois step for x^8+x^4+x^3+x^2+1: rotate left, fold s7 into taps
  function automatic logic [LFSR_W-1:0] lfsr_next(
    input logic [LFSR_W-1:0] s
  );
    logic [LFSR_W-1:0] r;
    r = {s[LFSR_W-2:0], s[LFSR_W-1]};
    if (s[LFSR_W-1]) r = r ^ TAPS;
    return r;
  endfunction

  // All-zero is the lock-up state, never let it in
  function automatic logic [LFSR_W-1:0] seed_fix(
    input logic [LFSR_W-1:0] s
  );
    return (s == '0) ? ZERO_SUB : s;
  endfunction

endpackage

// File: rtl/lfsr_core.sv
// 8-bit Galois LFSR register with load, step and hold (load wins).
// Ports: clk, res_n (sync, active-low), load, step, load_val, q.
module lfsr_core
  import lfsr_pkg::*;
#(
  parameter logic [LFSR_W-1:0] RESET_VAL = ZERO_SUB
) (
  input  logic              clk,
  input  logic              res_n,
  input  logic              load,
  input  logic              step,
  input  logic [LFSR_W-1:0] load_val,
  output logic [LFSR_W-1:0] q
);

  always_ff @(posedge clk) begin
    if (!res_n)    q <= RESET_VAL;
    else if (load) q <= load_val;
    else if (step) q <= lfsr_next(q);
  end

endmodule

// File: rtl/lfsr_rng_ctrl.sv
// LFSR random-byte server: seeding, warm-up, round-robin req/ack for two
// requesters. Ports: clk, res_n, seed_in, seed_load, req[1:0], ack[1:0],
// rnd_data[7:0], ready; gnt_cnt0/gnt_cnt1 when LFSR_GNT_CNT_EN is defined.
module lfsr_rng_ctrl
  import lfsr_pkg::*;
#(
  parameter logic [7:0] RESET_SEED = 8'h01,
  parameter int         WARMUP     = 8
) (
  input  logic       clk,
  input  logic       res_n,
  input  logic [7:0] seed_in,
  input  logic       seed_load,
  input  logic [1:0] req,
  output logic [1:0] ack,
  output logic [7:0] rnd_data,
  output logic       ready
`ifdef LFSR_GNT_CNT_EN
  ,
  output logic [7:0] gnt_cnt0,
  output logic [7:0] gnt_cnt1
`endif
);

  localparam logic [7:0] WLAST =
    (WARMUP == 0) ? 8'd0 : 8'(WARMUP - 1);
  localparam state_t START =
    (WARMUP == 0) ? READY : WARM;

  state_t      state, state_n;
  logic [7:0]  warm_cnt, warm_n;
  logic        rr, rr_n;
  logic [1:0]  ack_n;
  logic [7:0]  data_n;
  logic        load, step, w;
  logic [7:0]  lfsr;

  lfsr_core #(
    .RESET_VAL (seed_fix(RESET_SEED))
  ) u_core (
    .clk      (clk),
    .res_n    (res_n),
    .load     (load),
    .step     (step),
    .load_val (seed_fix(seed_in)),
    .q        (lfsr)
  );

  always_comb begin
    state_n = state;
    warm_n  = warm_cnt;
    rr_n    = rr;
    ack_n   = 2'b00;
    data_n  = rnd_data;
    load    = 1'b0;
    step    = 1'b0;
    w       = 1'b0;
    if (seed_load) begin
      load    = 1'b1;
      warm_n  = 8'd0;
      state_n = START;
    end else begin
      unique case (state)
        WARM: begin
          step   = 1'b1;
          warm_n = warm_cnt + 8'd1;
          if (warm_cnt == WLAST) state_n = READY;
        end
        READY: begin
          if (|req) begin
            // contested: rr picks; otherwise the lone requester
            w       = (&req) ? rr : req[1];
            ack_n   = w ? 2'b10 : 2'b01;
            data_n  = lfsr;
            step    = 1'b1;
            rr_n    = ~w;
            state_n = ACK;
          end
        end
        ACK:     state_n = READY;
        default: state_n = START;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (!res_n) begin
      state    <= START;
      warm_cnt <= 8'd0;
      rr       <= 1'b0;
      ack      <= 2'b00;
      rnd_data <= 8'h00;
      ready    <= (START == READY);
    end else begin
      state    <= state_n;
      warm_cnt <= warm_n;
      rr       <= rr_n;
      ack      <= ack_n;
      rnd_data <= data_n;
      ready    <= (state_n == READY);
    end
  end

`ifdef LFSR_GNT_CNT_EN
  // counts track the ack register, so they update with it
  always_ff @(posedge clk) begin
    if (!res_n) begin
      gnt_cnt0 <= 8'd0;
      gnt_cnt1 <= 8'd0;
    end else begin
      if (ack_n[0]) gnt_cnt0 <= gnt_cnt0 + 8'd1;
      if (ack_n[1]) gnt_cnt1 <= gnt_cnt1 + 8'd1;
    end
  end
`endif

endmodule

// File: tb/tb_lfsr_rng_ctrl.sv
// Self-checking bench for lfsr_rng_ctrl: directed scenarios plus random
// req/seed/reset traffic against a behavioural model of the server.
module tb_lfsr_rng_ctrl;

  localparam logic [7:0] SEED0 = 8'h01;
  localparam int         WUP   = 8;

  logic       clk = 1'b0;
  logic       res_n;
  logic [7:0] seed_in;
  logic       seed_load;
  logic [1:0] req;
  logic [1:0] ack;
  logic [7:0] rnd_data;
  logic       ready;
`ifdef LFSR_GNT_CNT_EN
  logic [7:0] gnt_cnt0, gnt_cnt1;
`endif

  lfsr_rng_ctrl #(
    .RESET_SEED (SEED0),
    .WARMUP     (WUP)
  ) dut (
    .clk       (clk),
    .res_n     (res_n),
    .seed_in   (seed_in),
    .seed_load (seed_load),
    .req       (req),
    .ack       (ack),
    .rnd_data  (rnd_data),
    .ready     (ready)
`ifdef LFSR_GNT_CNT_EN
    ,
    .gnt_cnt0  (gnt_cnt0),
    .gnt_cnt1  (gnt_cnt1)
`endif
  );

  always #5 clk = ~clk;

  int checks = 0;
  int failures = 0;

  // model: byte value, warm cycles left, ack-cooldown flag, rr pointer
  int m_lfsr, m_wait, m_cool, m_rr, m_ack, m_data, m_c0, m_c1;
  int prev_ack;

  task automatic check(input string tag, input int got, input int exp);
    checks++;
    if (got != exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t",
               tag, got, exp, $time);
    end
  endtask

  // polynomial multiply-by-x modulo x^8+x^4+x^3+x^2+1
  function automatic int nxt(input int v);
    int r;
    r = v * 2;
    if (r > 255) r = r ^ 'h11D;
    return r;
  endfunction

  function automatic int fix(input int v);
    return (v == 0) ? 1 : v;
  endfunction

  task automatic model_step();
    int w;
    if (!res_n) begin
      m_lfsr = fix(int'(SEED0));
      m_wait = WUP; m_cool = 0; m_rr = 0;
      m_ack = 0; m_data = 0; m_c0 = 0; m_c1 = 0;
    end else if (seed_load) begin
      m_lfsr = fix(int'(seed_in));
      m_wait = WUP; m_cool = 0; m_ack = 0;
    end else if (m_wait > 0) begin
      m_lfsr = nxt(m_lfsr); m_wait--; m_ack = 0;
    end else if (m_cool != 0) begin
      m_cool = 0; m_ack = 0;
    end else if (req != 2'b00) begin
      if (req == 2'b11) w = m_rr;
      else w = (req == 2'b10) ? 1 : 0;
      m_ack = 1 << w;
      m_data = m_lfsr;
      m_lfsr = nxt(m_lfsr);
      m_rr = 1 - w;
      m_cool = 1;
      if (w == 0) m_c0 = (m_c0 + 1) % 256;
      else m_c1 = (m_c1 + 1) % 256;
    end else begin
      m_ack = 0;
    end
  endtask

  task automatic tick();
    model_step();
    @(posedge clk);
    #1;
    check("ack", int'(ack), m_ack);
    check("rnd_data", int'(rnd_data), m_data);
    check("ready", int'(ready), (m_wait == 0 && m_cool == 0) ? 1 : 0);
    check("ack_gap", (ack != 0 && prev_ack != 0) ? 1 : 0, 0);
`ifdef LFSR_GNT_CNT_EN
    check("gnt_cnt0", int'(gnt_cnt0), m_c0);
    check("gnt_cnt1", int'(gnt_cnt1), m_c1);
`endif
    prev_ack = int'(ack);
  endtask

  task automatic wait_ack(output int a, output int d);
    a = 0; d = 0;
    for (int i = 0; i < 6; i++) begin
      tick();
      if (ack != 2'b00) begin
        a = int'(ack); d = int'(rnd_data);
        return;
      end
    end
    check("ack_timeout", 0, 1);
  endtask

  task automatic do_reset();
    res_n = 1'b0;
    tick();
    tick();
    res_n = 1'b1;
  endtask

  int a, d, exp_d;
  int exp_a4 [4] = '{1, 2, 1, 2};
  int exp_d4 [4] = '{'h1D, 'h3A, 'h74, 'hE8};

  initial begin
    res_n = 1'b0; seed_in = 8'h00; seed_load = 1'b0; req = 2'b00;
    prev_ack = 0;
    #1;
    do_reset();
    for (int i = 0; i < WUP; i++) begin
      tick();
      check("warm_ready", int'(ready), (i == WUP - 1) ? 1 : 0);
    end

    // single requester, three grants
    for (int k = 0; k < 3; k++) begin
      req = 2'b01;
      wait_ack(a, d);
      check("solo_ack", a, 1);
      check("solo_data", d, exp_d4[k]);
      req = 2'b00;
      tick();
    end

    // both requesters held: alternation from rr=0 after reset
    do_reset();
    for (int i = 0; i < WUP; i++) tick();
    req = 2'b11;
    for (int k = 0; k < 4; k++) begin
      wait_ack(a, d);
      check("rr_ack", a, exp_a4[k]);
      check("rr_data", d, exp_d4[k]);
    end

    // reseed during the ACK cycle; rr continues from requester 0
    seed_in = 8'h55; seed_load = 1'b1;
    tick();
    seed_load = 1'b0;
    check("seed_in_ack_ready", int'(ready), 0);
    for (int i = 0; i < WUP; i++) tick();
    exp_d = 'h55;
    for (int i = 0; i < WUP; i++) exp_d = nxt(exp_d);
    wait_ack(a, d);
    check("seed_ack_who", a, 1);
    check("seed_ack_data", d, exp_d);

    // zero seed in READY maps to 0x01
    req = 2'b00;
    tick();
    seed_in = 8'h00; seed_load = 1'b1;
    tick();
    seed_load = 1'b0;
    for (int i = 0; i < WUP; i++) begin
      tick();
      check("reseed_ready", int'(ready), (i == WUP - 1) ? 1 : 0);
    end
    req = 2'b01;
    wait_ack(a, d);
    check("zero_seed_data", d, 'h1D);
    req = 2'b00;
    tick();

`ifdef LFSR_GNT_CNT_EN
    do_reset();
    for (int i = 0; i < WUP; i++) tick();
    for (int k = 0; k < 300; k++) begin
      req = 2'b01;
      wait_ack(a, d);
      req = 2'b00;
      tick();
    end
    check("cnt0_wrap", int'(gnt_cnt0), 44);
    check("cnt1_zero", int'(gnt_cnt1), 0);
    res_n = 1'b0;
    tick();
    res_n = 1'b1;
    check("cnt0_rst", int'(gnt_cnt0), 0);
    check("cnt1_rst", int'(gnt_cnt1), 0);
`endif

    // random traffic: requesters hold until acked
    for (int c = 0; c < 3000; c++) begin
      for (int b = 0; b < 2; b++)
        if (!req[b] && $urandom_range(3) == 0) req[b] = 1'b1;
      seed_load = ($urandom_range(39) == 0);
      seed_in = ($urandom_range(3) == 0) ? 8'h00 : 8'($urandom);
      res_n = ($urandom_range(299) != 0);
      tick();
      req = req & ~ack;
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
